// File: rtl/smvm_pkg.sv
// Shared types for the SMVM entry stream.
// States, COO entry layout and entry width.
package smvm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    TERM
  } state_e;

  typedef struct packed {
    logic [31:0] row;
    logic [31:0] col;
    logic [31:0] value;
  } coo_entry_t;

  localparam int ENTRY_W = 96;

endpackage

// File: rtl/coo_channel_streamer_reg.sv
// Plain register primitive with async active-low clear.
// Used for the per-lane output registers.
module coo_channel_streamer_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // capture d every cycle, clear on reset
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) q <= '0;
    else        q <= d;
  end

endmodule

// File: rtl/coo_channel_streamer.sv
// Multi-lane COO entry producer for the SMVM pipe.
// Fetches packed words and ends with row sentinels.
module coo_channel_streamer
  import smvm_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int MATRIX_SIZE  = 128,
  parameter int ADDR_W       = 10
) (
  input  logic                         clk,
  input  logic                         rst_l,
  input  logic                         start,
  input  logic [31:0]                  nnz,
  input  logic [ADDR_W-1:0]            base_addr,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic                         mem_rd,
  input  logic [NUM_CHANNELS*ENTRY_W-1:0] mem_rdata,
  output logic [NUM_CHANNELS*32-1:0]   values,
  output logic [NUM_CHANNELS*32-1:0]   col_id,
  output logic [NUM_CHANNELS*32-1:0]   row_id,
  output logic                         rdy,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int LOG2 = $clog2(NUM_CHANNELS);
  localparam logic [31:0] SENT = 32'(MATRIX_SIZE);

  state_e state_q, state_d;
  logic [31:0] nnz_q, nnz_d;
  logic [31:0] words_q, words_d;
  logic [31:0] w_q, w_d;
  logic [31:0] pend_w_q, pend_w_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic rd_vld_q, rd_vld_d;
  logic rdy_q, rdy_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;
  logic accept;

  coo_entry_t lane_d [NUM_CHANNELS];
  coo_entry_t lane_q [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] lane_bad;
  logic [32:0] lane_e [NUM_CHANNELS];

  // next-state and start acceptance
  always_comb begin
    state_d = state_q;
    nnz_d   = nnz_q;
    words_d = words_q;
    w_d     = w_q;
    base_d  = base_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE, TERM: begin
        if (start) begin
          accept  = 1'b1;
          nnz_d   = nnz;
          base_d  = base_addr;
          w_d     = '0;
          words_d = 32'((33'(nnz) +
                    33'(NUM_CHANNELS - 1)) >> LOG2);
          state_d = (nnz == 32'd0) ? TERM : FETCH;
        end
      end
      FETCH: begin
        w_d = w_q + 32'd1;
        if (w_q == words_q - 32'd1) state_d = DRAIN;
      end
      DRAIN: state_d = TERM;
      default: state_d = IDLE;
    endcase
  end

  assign mem_rd   = (state_q == FETCH);
  assign mem_addr = mem_rd ? base_q + ADDR_W'(w_q) : '0;

  // format returning words into lanes; pad or sentinel otherwise
  always_comb begin
    lane_bad = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      lane_d[k] = '0;
      lane_e[k] = (33'(pend_w_q) << LOG2) + 33'(k);
      if (rd_vld_q) begin
        if (lane_e[k] < {1'b0, nnz_q}) begin
          lane_d[k] = coo_entry_t'(
            mem_rdata[k*ENTRY_W +: ENTRY_W]);
          lane_bad[k] = (lane_d[k].row >= SENT);
        end else begin
          lane_d[k].row = SENT;
        end
      end else if (state_q == TERM && !start) begin
        lane_d[k].row = SENT;
      end
    end
  end

  // status flags and read pipeline tracking
  always_comb begin
    rd_vld_d = (state_q == FETCH);
    pend_w_d = (state_q == FETCH) ? w_q : pend_w_q;
    rdy_d    = rd_vld_q;
    done_d   = (state_q == TERM) && !start;
    busy_d   = busy_q;
    if (accept)                busy_d = 1'b1;
    else if (state_q == TERM)  busy_d = 1'b0;
    err_d = accept ? 1'b0 : (err_q | (rd_vld_q & (|lane_bad)));
  end

  // control and status registers
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q  <= IDLE;
      nnz_q    <= '0;
      words_q  <= '0;
      w_q      <= '0;
      pend_w_q <= '0;
      base_q   <= '0;
      rd_vld_q <= 1'b0;
      rdy_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      nnz_q    <= nnz_d;
      words_q  <= words_d;
      w_q      <= w_d;
      pend_w_q <= pend_w_d;
      base_q   <= base_d;
      rd_vld_q <= rd_vld_d;
      rdy_q    <= rdy_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_lane
    coo_channel_streamer_reg #(
      .W(ENTRY_W)
    ) u_reg (
      .clk  (clk),
      .rst_l(rst_l),
      .d    (lane_d[k]),
      .q    (lane_q[k])
    );
    assign values[k*32 +: 32] = lane_q[k].value;
    assign col_id[k*32 +: 32] = lane_q[k].col;
    assign row_id[k*32 +: 32] = lane_q[k].row;
  end

  assign rdy  = rdy_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_coo_channel_streamer.sv
// Directed bench for coo_channel_streamer.
// Memory model returns data one cycle after mem_rd.
module tb_coo_channel_streamer;

  localparam int NC = 4;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic start = 1'b0;
  logic [31:0] nnz = '0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] mem_addr;
  logic mem_rd;
  logic [NC*96-1:0] mem_rdata = '0;
  logic [NC*32-1:0] values, col_id, row_id;
  logic rdy, busy, done, err;

  logic [NC*96-1:0] mem [1024];
  int checks = 0;
  int errors = 0;
  logic [4:0] ctl;

  coo_channel_streamer dut (
    .clk(clk), .rst_l(rst_l), .start(start), .nnz(nnz),
    .base_addr(base_addr), .mem_addr(mem_addr),
    .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .values(values), .col_id(col_id), .row_id(row_id),
    .rdy(rdy), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr];

  assign ctl = {mem_rd, rdy, busy, done, err};

  // entry e: row=e, col=e+10, value=e+1
  task automatic fill(input int n, input int base);
    for (int e = 0; e < n; e++) begin
      int a;
      a = (base + e / NC) & 'h3FF;
      mem[a][(e % NC)*96 +: 96] = {32'(e), 32'(e + 10), 32'(e + 1)};
    end
  endtask

  task automatic go(input int n, input int base);
    @(negedge clk);
    start = 1'b1; nnz = 32'(n); base_addr = AW'(base);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if (ctl !== 5'b0 || mem_addr !== '0 || row_id !== '0 ||
        values !== '0 || col_id !== '0) begin
      errors++;
      $display("FAIL reset_hold: ctl=%b row=%h want 0", ctl, row_id);
    end
    @(negedge clk); @(negedge clk);
    rst_l = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== 5'b0 || row_id !== '0) begin
      errors++;
      $display("FAIL reset_idle: ctl=%b row=%h want 0", ctl, row_id);
    end
  endtask

  task automatic test_basic;
    fill(8, 'h010);
    go(8, 'h010);
    checks++;
    if (ctl !== 5'b10100 || mem_addr !== 10'h010) begin
      errors++;
      $display("FAIL basic_c1: ctl=%b addr=%h want 10100/010", ctl, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b10100 || mem_addr !== 10'h011) begin
      errors++;
      $display("FAIL basic_c2: ctl=%b addr=%h want 10100/011", ctl, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b01100 || row_id !== {32'd3, 32'd2, 32'd1, 32'd0} ||
        values !== {32'd4, 32'd3, 32'd2, 32'd1} ||
        col_id !== {32'd13, 32'd12, 32'd11, 32'd10}) begin
      errors++;
      $display("FAIL basic_beat0: ctl=%b row=%h val=%h col=%h",
               ctl, row_id, values, col_id);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b01100 || row_id !== {32'd7, 32'd6, 32'd5, 32'd4} ||
        values !== {32'd8, 32'd7, 32'd6, 32'd5}) begin
      errors++;
      $display("FAIL basic_beat1: ctl=%b row=%h val=%h", ctl, row_id, values);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00010 || row_id !== {4{32'd128}} ||
        values !== '0 || col_id !== '0) begin
      errors++;
      $display("FAIL basic_term: ctl=%b row=%h val=%h want 00010/sentinel",
               ctl, row_id, values);
    end
  endtask

  task automatic test_partial;
    fill(5, 'h020);
    go(5, 'h020);
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'h021 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL partial_addr: addr=%h rd=%b want 021/1", mem_addr, mem_rd);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (ctl !== 5'b01100 ||
        row_id !== {32'd128, 32'd128, 32'd128, 32'd4} ||
        values !== {32'd0, 32'd0, 32'd0, 32'd5} ||
        col_id !== {32'd0, 32'd0, 32'd0, 32'd14}) begin
      errors++;
      $display("FAIL partial_beat1: ctl=%b row=%h val=%h col=%h",
               ctl, row_id, values, col_id);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00010 || row_id !== {4{32'd128}}) begin
      errors++;
      $display("FAIL partial_term: ctl=%b row=%h", ctl, row_id);
    end
  endtask

  task automatic test_zero;
    go(0, 'h000);
    checks++;
    if (ctl !== 5'b00100) begin
      errors++;
      $display("FAIL zero_c1: ctl=%b want 00100", ctl);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00010 || row_id !== {4{32'd128}}) begin
      errors++;
      $display("FAIL zero_c2: ctl=%b row=%h want 00010", ctl, row_id);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00010) begin
      errors++;
      $display("FAIL zero_hold: ctl=%b want 00010", ctl);
    end
  endtask

  task automatic test_err_restart;
    fill(4, 'h030);
    mem[10'h030][2*96+64 +: 32] = 32'd200;
    go(4, 'h030);
    @(negedge clk);
    checks++;
    if (ctl !== 5'b00100) begin
      errors++;
      $display("FAIL err_drain: ctl=%b want 00100", ctl);
    end
    @(negedge clk);
    checks++;
    if (ctl !== 5'b01101 || row_id !== {32'd3, 32'd200, 32'd1, 32'd0} ||
        values !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      errors++;
      $display("FAIL err_beat: ctl=%b row=%h val=%h", ctl, row_id, values);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (ctl !== 5'b00011) begin
      errors++;
      $display("FAIL err_sticky: ctl=%b want 00011", ctl);
    end
    fill(4, 'h040);
    go(4, 'h040);
    checks++;
    if (ctl !== 5'b10100 || mem_addr !== 10'h040) begin
      errors++;
      $display("FAIL restart: ctl=%b addr=%h want 10100/040", ctl, mem_addr);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_ignore;
    fill(8, 'h010);
    go(8, 'h010);
    start = 1'b1; nnz = 32'd1; base_addr = 10'h200;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (mem_addr !== 10'h011 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL ignore_addr: addr=%h want 011", mem_addr);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (row_id !== {32'd7, 32'd6, 32'd5, 32'd4} || rdy !== 1'b1) begin
      errors++;
      $display("FAIL ignore_beat: row=%h rdy=%b", row_id, rdy);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_wrap;
    fill(8, 'h3FF);
    go(8, 'h3FF);
    checks++;
    if (mem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL wrap_c1: addr=%h want 3ff", mem_addr);
    end
    @(negedge clk);
    checks++;
    if (mem_addr !== 10'h000 || mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL wrap_c2: addr=%h want 000", mem_addr);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if (row_id !== {32'd7, 32'd6, 32'd5, 32'd4} || err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_beat: row=%h err=%b", row_id, err);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    fill(64, 'h100);
    go(64, 'h100);
    @(negedge clk); @(negedge clk);
    checks++;
    if (rdy !== 1'b1 || row_id !== {32'd3, 32'd2, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL mid_pre: rdy=%b row=%h", rdy, row_id);
    end
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (ctl !== 5'b0 || mem_addr !== '0 || row_id !== '0 ||
        values !== '0 || col_id !== '0) begin
      errors++;
      $display("FAIL mid_async: ctl=%b row=%h want 0", ctl, row_id);
    end
    @(negedge clk);
    rst_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== 5'b0 || row_id !== '0) begin
        errors++;
        $display("FAIL mid_idle%0d: ctl=%b row=%h want 0", i, ctl, row_id);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time expired");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '1;
    test_reset();
    test_basic();
    test_partial();
    test_zero();
    test_err_restart();
    test_ignore();
    test_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
